// File: rtl/ofm_writeback_packer.sv
// OFM writeback packer: captures 16 PE bytes per pixel, FIFOs them, and writes four
// 32-bit NHWC words per pixel to OFM BRAM. Optional running checksum: OFM_WB_CHECKSUM_EN.
module ofm_writeback_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        OFM_W,
  input  logic [7:0]        OFM_C,
  input  logic [15:0]       valid,
  input  logic [127:0]      ofm_in,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              partial_err,
  output logic [31:0]       checksum
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [127:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [1:0]        word;
  logic [7:0]        cfg_w;
  logic [5:0]        cfg_c4;
  logic [3:0]        cfg_ngrp;
  logic [7:0]        col, row;
  logic [3:0]        grp;
  logic [ADDR_W-1:0] grp_base, pix_addr;

  logic         running, fifo_full, full_pulse, partial, push, pop;
  logic         last_col, last_row, last_grp, finish;
  logic [127:0] head;
  logic         unused_ok;

  assign unused_ok = &{1'b0, OFM_C[1:0]};

  always_comb begin
    running    = (state == S_RUN);
    fifo_full  = (count == FULL_CNT);
    full_pulse = running && !start && (valid == '1);
    partial    = running && !start && (valid != '0) && (valid != '1);
    mem_wr_en  = running && (count != '0);
    pop        = mem_wr_en && (word == 2'd3);
    // A full FIFO still accepts when its head is retired on the same edge
    push       = full_pulse && (!fifo_full || pop);
    last_col   = (col == cfg_w - 8'd1);
    last_row   = (row == cfg_w - 8'd1);
    last_grp   = (grp == cfg_ngrp - 4'd1);
    finish     = pop && last_col && last_row && last_grp;
    head       = fifo_mem[rd_ptr];
    mem_wr_data = {head[{word, 5'd0} +: 8], head[{word, 5'd8} +: 8],
                   head[{word, 5'd16} +: 8], head[{word, 5'd24} +: 8]};
    mem_addr   = pix_addr + ADDR_W'(word);
  end

  always_ff @(posedge clk) begin
    if (push && !reset) fifo_mem[wr_ptr] <= ofm_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      word        <= '0;
      cfg_w       <= '0;
      cfg_c4      <= '0;
      cfg_ngrp    <= '0;
      col         <= '0;
      row         <= '0;
      grp         <= '0;
      grp_base    <= '0;
      pix_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      partial_err <= 1'b0;
    end else if (start) begin
      state       <= S_RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      word        <= '0;
      cfg_w       <= OFM_W;
      cfg_c4      <= OFM_C[7:2];
      cfg_ngrp    <= OFM_C[7:4];
      col         <= '0;
      row         <= '0;
      grp         <= '0;
      grp_base    <= base_addr;
      pix_addr    <= base_addr;
      busy        <= 1'b1;
      done        <= 1'b0;
      overflow    <= 1'b0;
      partial_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (full_pulse && !push) overflow <= 1'b1;
      if (partial) partial_err <= 1'b1;
      if (mem_wr_en) word <= word + 2'd1;
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
      // Pixel loop is inner, group loop outer; addresses advance by adds only
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row      <= '0;
            grp      <= grp + 4'd1;
            grp_base <= grp_base + ADDR_W'(4);
            pix_addr <= grp_base + ADDR_W'(4);
          end else begin
            row      <= row + 8'd1;
            pix_addr <= pix_addr + ADDR_W'(cfg_c4);
          end
        end else begin
          col      <= col + 8'd1;
          pix_addr <= pix_addr + ADDR_W'(cfg_c4);
        end
      end
      if (finish) begin
        state <= S_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        count <= '0;
      end
    end
  end

`ifdef OFM_WB_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start) checksum <= '0;
    else if (mem_wr_en) checksum <= checksum + mem_wr_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Bench for ofm_writeback_packer: table of run configurations plus hand sequences
// for overflow, partial valid and mid-drain reset; writes checked by a scoreboard queue.
module tb_ofm_writeback_packer;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [19:0]   base_addr;
  logic [7:0]    OFM_W, OFM_C;
  logic [15:0]   valid;
  logic [127:0]  ofm_in;
  logic          mem_wr_en;
  logic [19:0]   mem_addr;
  logic [31:0]   mem_wr_data;
  logic          busy, done, overflow, partial_err;
  logic [31:0]   checksum;

  ofm_writeback_packer #(.FIFO_DEPTH(4), .ADDR_W(20)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .OFM_W(OFM_W), .OFM_C(OFM_C), .valid(valid), .ofm_in(ofm_in),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .overflow(overflow), .partial_err(partial_err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int unsigned w, c, base, gap;
    int unsigned spot_a0; logic [31:0] spot_d0;
    int unsigned spot_a1; logic [31:0] spot_d1;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] wmem [int unsigned];
  int          n_cmp = 0, n_bad = 0, wr_cnt = 0;
  logic [31:0] sw_sum = '0;
  int unsigned cur_w, cur_c, cur_base;
  vec_t        vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pix_pattern(input int unsigned n);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'((16*n + k) & 255);
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input int unsigned n, input int unsigned w);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'((16*n + 4*w + j) & 255);
    return r;
  endfunction

  function automatic logic [31:0] getw(input int unsigned a);
    return wmem.exists(a) ? wmem[a] : 32'hDEADBEEF;
  endfunction

  task automatic enqueue(input int unsigned n);
    int unsigned npx, pix, grp;
    wr_t x;
    npx = cur_w * cur_w;
    pix = n % npx;
    grp = n / npx;
    for (int w = 0; w < 4; w++) begin
      x.addr = 20'((cur_base + pix*(cur_c/4) + grp*4 + w) & 32'hFFFFF);
      x.data = exp_word(n, w);
      exp_q.push_back(x);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic send_pulse(input int unsigned n, input bit enq);
    valid  = '1;
    ofm_in = pix_pattern(n);
    if (enq) enqueue(n);
    @(posedge clk); #1;
    valid  = '0;
    ofm_in = '0;
  endtask

  task automatic send_bad(input logic [15:0] v);
    valid = v;
    ofm_in = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    @(posedge clk); #1;
    valid = '0;
  endtask

  task automatic do_start(input int unsigned w, input int unsigned c, input int unsigned b);
    cur_w = w; cur_c = c; cur_base = b;
    exp_q.delete(); wmem.delete(); wr_cnt = 0; sw_sum = '0;
    OFM_W = 8'(w); OFM_C = 8'(c); base_addr = 20'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    OFM_W = 8'd7; OFM_C = 8'd64; base_addr = 20'h5A5A5;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400 && done !== 1'b1; i++) begin @(posedge clk); #1; end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic check_sum(input string name);
`ifdef OFM_WB_CHECKSUM_EN
    check(name, checksum, sw_sum);
`else
    check(name, checksum, 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wr_cnt++;
      wmem[mem_addr] = mem_wr_data;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr 0x%05h data 0x%08h, expected no write",
                 mem_addr, mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        sw_sum += e.data;
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wr_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int unsigned total;
    vecs[0] = '{2, 16, 32'h0,     4, 32'h0,     32'h00010203, 32'h5,     32'h14151617};
    vecs[1] = '{2, 32, 32'h100,   5, 32'h108,   32'h10111213, 32'h104,   32'h40414243};
    vecs[2] = '{3, 48, 32'h2345,  4, 32'h2345,  32'h00010203, 32'h23AD,  32'hA0A1A2A3};
    vecs[3] = '{2, 32, 32'hFFFF8, 6, 32'hFFFF8, 32'h00010203, 32'h14,    32'h70717273};
    vecs[4] = '{1, 240, 32'h10,   4, 32'h10,    32'h00010203, 32'h48,    32'hE0E1E2E3};

    reset = 1'b1; start = 1'b0; valid = '0; ofm_in = '0;
    base_addr = '0; OFM_W = '0; OFM_C = '0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("rst_wr_en", 32'(mem_wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_partial", 32'(partial_err), 0);
    check("rst_checksum", checksum, 0);

    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].w, vecs[v].c, vecs[v].base);
      check("busy_after_start", 32'(busy), 1);
      total = vecs[v].w * vecs[v].w * (vecs[v].c / 16);
      for (int unsigned n = 0; n < total; n++) begin
        send_pulse(n, 1'b1);
        idle(vecs[v].gap - 1);
      end
      wait_done("run_done");
      check("run_busy", 32'(busy), 0);
      check("run_overflow", 32'(overflow), 0);
      check("run_partial", 32'(partial_err), 0);
      check("run_writes", 32'(wr_cnt), 32'(4*total));
      check("run_queue_left", 32'(exp_q.size()), 0);
      check("run_spot0", getw(vecs[v].spot_a0), vecs[v].spot_d0);
      check("run_spot1", getw(vecs[v].spot_a1), vecs[v].spot_d1);
      check_sum("run_checksum");
      send_pulse(200, 1'b0);
      idle(6);
      check("post_done_level", 32'(done), 1);
      check("post_done_writes", 32'(wr_cnt), 32'(4*total));
    end

    // Overflow: six back-to-back pulses into a 4-deep FIFO
    do_start(3, 16, 0);
    for (int unsigned n = 0; n < 6; n++) send_pulse(n, n < 5);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    idle(3);
    check("ovf_writes", 32'(wr_cnt), 20);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_busy", 32'(busy), 1);
    check("ovf_done", 32'(done), 0);
    for (int unsigned n = 5; n < 9; n++) begin send_pulse(n, 1'b1); idle(3); end
    wait_done("ovf_done_end");
    check("ovf_writes_end", 32'(wr_cnt), 36);
    check("ovf_flag_end", 32'(overflow), 1);

    // Partial valid mid-run, plus first-write latency
    do_start(2, 16, 32'h30);
    send_pulse(0, 1'b1);
    check("lat_wr_en", 32'(mem_wr_en), 1);
    check("lat_addr", 32'(mem_addr), 32'h30);
    idle(5);
    send_bad(16'h00FF);
    check("partial_flag", 32'(partial_err), 1);
    check("partial_no_write", 32'(mem_wr_en), 0);
    for (int unsigned n = 1; n < 4; n++) begin send_pulse(n, 1'b1); idle(3); end
    wait_done("partial_done");
    check("partial_pix1", getw(32'h34), 32'h10111213);
    check("partial_writes", 32'(wr_cnt), 16);
    check("partial_overflow", 32'(overflow), 0);
    check("partial_sticky", 32'(partial_err), 1);

    // Reset while word 2 of a pixel is on the bus
    do_start(2, 16, 32'h40);
    send_bad(16'h0001);
    send_pulse(0, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (mem_wr_en === 1'b1 && mem_addr === 20'h42) hit = 1'b1;
    end
    check("rst_mid_seen_w2", 32'(hit), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_wr_en", 32'(mem_wr_en), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_done", 32'(done), 0);
    check("rstmid_partial", 32'(partial_err), 0);
    check("rstmid_overflow", 32'(overflow), 0);
    check("rstmid_checksum", checksum, 0);
    reset = 1'b0;
    exp_q.delete();
    idle(4);
    check("rstmid_idle_wr_en", 32'(mem_wr_en), 0);
    do_start(2, 16, 0);
    for (int unsigned n = 0; n < 4; n++) begin send_pulse(n, 1'b1); idle(3); end
    wait_done("rstmid_rerun_done");
    check("rstmid_rerun_addr0", getw(0), 32'h00010203);
    check("rstmid_rerun_writes", 32'(wr_cnt), 16);
    check_sum("rstmid_rerun_checksum");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
